// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

  // Default operand width and the bit-counter width it needs.
  localparam int SUB_WIDTH_DEF = 3;
  localparam int CNT_W         = $clog2(SUB_WIDTH_DEF);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Borrow out when x is 0 and y is 1, or when x == y and a borrow comes in.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  // Counter must reach WIDTH-1; never narrower than the package default.
  localparam int CW = ($clog2(WIDTH) > CNT_W) ? $clog2(WIDTH) : CNT_W;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d, cell_bo;
  logic             accept;

  full_subtractor u_cell (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign accept = start && (state_q == IDLE || state_q == DONE);

  // Next-state: load on accept, one bit per SHIFT cycle, publish result on entry to DONE.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d  = SHIFT;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          res_d    = '0;
          cnt_d    = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = {cell_d, res_q[WIDTH-1:1]};
        borrow_d = cell_bo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          // diff only moves here, so it never shows partial results.
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_bo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Status flags are pure decodes of the state register.
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=3).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] a, b;
  logic       bin;
  logic [2:0] diff;
  logic       bout, busy, done;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .bout(bout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic       bin;
    logic [2:0] ed;
    logic       eb;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then wait for done; also watch diff stays put while busy.
  task automatic run_op(input logic [2:0] ia, input logic [2:0] ib, input logic ibin,
                        output logic [2:0] od, output logic ob,
                        output int bcnt, output bit got, output bit glitch);
    logic [2:0] held;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    held = diff;
    @(negedge clk);
    start = 1'b0;
    bcnt = 0; got = 1'b0; glitch = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) bcnt++;
        if (diff != held) glitch = 1'b1;
        @(negedge clk);
      end
    end
    od = diff; ob = bout;
  endtask

  function automatic logic [3:0] model(input logic [2:0] ma, input logic [2:0] mb, input logic mbin);
    logic [3:0] r;
    r = {1'b0, ma} - {1'b0, mb} - {3'b0, mbin};
    // bit 3 is the borrow out of a 3-bit subtraction
    return {(int'(ma) < int'(mb) + int'(mbin)), r[2:0]};
  endfunction

  initial begin
    logic [2:0] od;
    logic       ob;
    int         bc, n;
    bit         got, gl, extra;
    logic [3:0] m;

    tbl[0] = '{3'd5, 3'd3, 1'b0, 3'd2, 1'b0};
    tbl[1] = '{3'd3, 3'd5, 1'b0, 3'd6, 1'b1};
    tbl[2] = '{3'd0, 3'd0, 1'b1, 3'd7, 1'b1};
    tbl[3] = '{3'd7, 3'd7, 1'b0, 3'd0, 1'b0};
    tbl[4] = '{3'd7, 3'd0, 1'b1, 3'd6, 1'b0};
    tbl[5] = '{3'd0, 3'd7, 1'b0, 3'd1, 1'b1};
    tbl[6] = '{3'd4, 3'd4, 1'b1, 3'd7, 1'b1};
    tbl[7] = '{3'd6, 3'd1, 1'b0, 3'd5, 1'b0};
    tbl[8] = '{3'd1, 3'd0, 1'b1, 3'd0, 1'b0};
    tbl[9] = '{3'd2, 3'd3, 1'b1, 3'd6, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_diff", diff, 0);
    chk("reset_bout", bout, 0);
    rst = 1'b0;

    // Table of single operations
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, od, ob, bc, got, gl);
      chk($sformatf("vec%0d_done", i), got, 1);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 3);
      chk($sformatf("vec%0d_diff", i), od, tbl[i].ed);
      chk($sformatf("vec%0d_bout", i), ob, tbl[i].eb);
      chk($sformatf("vec%0d_no_glitch", i), gl, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // Hold: 5-3 result persists 10 cycles later
    run_op(3'd5, 3'd3, 1'b0, od, ob, bc, got, gl);
    repeat (10) @(negedge clk);
    chk("hold_diff", diff, 2);
    chk("hold_bout", bout, 0);
    chk("hold_done", done, 0);
    chk("hold_busy", busy, 0);

    // Exhaustive sweep with start held high
    @(negedge clk);
    a = 3'd0; b = 3'd0; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 128; i++) begin
      #1;
      if (i < 127) begin
        a = 3'((i + 1) >> 4); b = 3'((i + 1) >> 1); bin = 1'((i + 1));
      end else start = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 8) begin
        @(negedge clk); n++;
        if (done) got = 1'b1;
      end
      m = model(3'(i >> 4), 3'(i >> 1), 1'(i));
      chk($sformatf("sweep%0d_spacing", i), got ? n : -1, 4);
      chk($sformatf("sweep%0d_diff", i), diff, m[2:0]);
      chk($sformatf("sweep%0d_bout", i), bout, m[3]);
      @(posedge clk);
    end
    repeat (3) @(negedge clk);

    // start during SHIFT is ignored
    @(negedge clk);
    a = 3'd6; b = 3'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 3'd7; b = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 8) begin
      if (done) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("ign_done", got, 1);
    chk("ign_diff", diff, 5);
    chk("ign_bout", bout, 0);
    extra = 1'b0;
    repeat (8) begin @(negedge clk); if (done || busy) extra = 1'b1; end
    chk("ign_no_extra", extra, 0);

    // Reset in the 2nd SHIFT cycle aborts
    @(negedge clk);
    a = 3'd5; b = 3'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    extra = 1'b0;
    repeat (6) begin @(negedge clk); if (done || busy) extra = 1'b1; end
    chk("abort_no_done", extra, 0);
    run_op(3'd7, 3'd7, 1'b0, od, ob, bc, got, gl);
    chk("post_abort_done", got, 1);
    chk("post_abort_diff", od, 0);
    chk("post_abort_bout", ob, 0);

    // rst and start on the same edge: reset wins
    @(negedge clk);
    a = 3'd1; b = 3'd2; bin = 1'b0; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_vs_start_busy", busy, 0);
    chk("rst_vs_start_done", done, 0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_vs_start_busy2", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
